// File: rtl/serial_rx_framer.sv
// serial_rx_framer: oversampled async serial receiver with a small word FIFO.
// Optional parity stage is enabled by defining SERIAL_RX_PARITY_EN.
//
// Parameters:
//   DATA_W      data bits per frame (5..16)
//   OVERSAMPLE  baud_tick pulses per bit period (even, 4..64)
//   FIFO_DEPTH  received-word buffer entries (power of two, 2..16)
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          serial line, idle high, asynchronous to clk
//   baud_tick    one-clk enable at OVERSAMPLE x baud rate
//   rx_data      FIFO head word, LSB received first
//   rx_valid     FIFO non-empty
//   rx_ready     consumer accepts head word
//   frame_err    pulse: stop bit sampled low
//   overrun      pulse: completed word dropped, FIFO full
//   parity_err   pulse: parity mismatch (parity build only)
//   busy         receiver not idle
module serial_rx_framer #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              baud_tick,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err,
    output logic              busy
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [FCNT_W-1:0] DEPTH    = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronizer. sync_vld marks when sync[1] holds a real
    // sample of din rather than its reset value; armed requires the
    // line to be seen high first, so a line that is already low at
    // reset release is not mistaken for a start bit.
    // ---------------------------------------------------------------
    logic [1:0] sync;
    logic [1:0] sync_vld;
    logic       armed;
    logic       din_s;

    assign din_s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b11;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            sync     <= {sync[0], din};
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && din_s)
                armed <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              mid_bit;
    logic              stop_smp;
    logic              par_bad;
    logic              push;
    logic              pop;
    logic              full;
    logic [FCNT_W-1:0] count;

`ifdef SERIAL_RX_PARITY_EN
    logic par_bit;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{shift_reg, par_bit};
`else
    assign par_bad = 1'b0;
`endif

    assign mid_bit  = (tick_cnt == FULL_M1);
    assign stop_smp = baud_tick && (state == S_STOP) && mid_bit;
    assign push     = stop_smp && din_s && !par_bad;
    assign pop      = rx_valid && rx_ready;
    assign full     = (count == DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit    <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            if (baud_tick) begin
                unique case (state)
                    S_IDLE: begin
                        if (armed && !din_s) begin
                            state    <= S_START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick_cnt == HALF_M1) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (din_s) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (mid_bit) begin
                            tick_cnt  <= '0;
                            shift_reg <= {din_s, shift_reg[DATA_W-1:1]};
                            bit_cnt   <= bit_cnt + BIT_W'(1);
                            if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    S_PARITY: begin
                        if (mid_bit) begin
                            tick_cnt <= '0;
                            par_bit  <= din_s;
                            state    <= S_STOP;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (mid_bit) begin
                            tick_cnt <= '0;
                            // A low stop bit outranks a parity mismatch.
                            if (!din_s) begin
                                frame_err <= 1'b1;
                                state     <= S_BREAK;
                            end else begin
                                parity_err <= par_bad;
                                state      <= S_IDLE;
                                busy       <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    S_BREAK: begin
                        if (din_s) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------
    // Word FIFO. A push into a full FIFO is accepted only when the
    // head is popped on the same edge; otherwise the word is dropped.
    // ---------------------------------------------------------------
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;

    assign do_push  = push && (!full || pop);
    assign rx_data  = mem[rd_ptr];
    assign rx_valid = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            overrun <= push && full && !pop;
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_push && !pop)
                count <= count + FCNT_W'(1);
            else if (!do_push && pop)
                count <= count - FCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_rx_framer.sv
// tb_serial_rx_framer: scenario tasks plus randomized frames checked
// against a queue-based model of the received word stream.
module tb_serial_rx_framer;

    localparam int DW = 8;
    localparam int OS = 16;
    localparam int FD = 4;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din;
    logic          baud_tick;
    logic          rx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          parity_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vld_cyc = 0;
    logic [DW-1:0] got_q[$];

    bit rand_rdy = 1'b0;

    always #5 clk = ~clk;

    serial_rx_framer #(
        .DATA_W(DW),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .baud_tick(baud_tick),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err),
        .busy(busy)
    );

    // Monitor samples mid-cycle; a pop is recorded when the consumer
    // handshake is present ahead of the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            if (rx_valid) vld_cyc++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (parity_err) pe_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // One tick period: 3 clocks, din changed at the start, tick on
    // the third clock so the synchronized line is settled.
    task automatic period(input logic v, input bit rp);
        din = v;
        if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        baud_tick = 1'b1;
        if (rp) rx_ready = 1'b1;
        else if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        baud_tick = 1'b0;
        if (rp) rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) period(1'b1, 1'b0);
    endtask

    // Bit b spans ticks b*OS+1 .. b*OS+OS counted from the falling
    // edge; its mid-bit sample is tick b*OS + OS/2 + 1.
    task automatic send_frame(input logic [DW-1:0] d, input logic stp,
                              input logic pb, input bit rp);
        int nb;
        nb = DW + 2 + (PAR ? 1 : 0);
        for (int b = 0; b < nb; b++) begin
            logic v;
            if (b == 0) v = 1'b0;
            else if (b <= DW) v = d[b-1];
            else if (PAR && b == DW + 1) v = pb;
            else v = stp;
            for (int p = 1; p <= OS; p++)
                period(v, rp && (b == nb - 1) && (p == OS / 2 + 1));
        end
    endtask

    task automatic drain(input int n);
        rx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; din = 1'b1; baud_tick = 1'b0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b want 0", rx_valid);
        end
        checks++;
        if (rx_data !== '0) begin
            errors++; $display("FAIL rst_data: got %0h want 0", rx_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        checks++;
        if ({frame_err, overrun, parity_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_pulses: got %b want 000",
                     {frame_err, overrun, parity_err});
        end
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single;
        int g0, v0, f0, o0, p0;
        logic [DW-1:0] d;
        d = 8'hA5;
        g0 = got_q.size(); v0 = vld_cyc;
        f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        rx_ready = 1'b1;
        send_frame(d, 1'b1, ^d, 1'b0);
        idle(8);
        rx_ready = 1'b0;
        checks++;
        if (got_q.size() - g0 !== 1) begin
            errors++;
            $display("FAIL single_cnt: got %0d want 1", got_q.size() - g0);
        end else begin
            checks++;
            if (got_q[g0] !== d) begin
                errors++;
                $display("FAIL single_data: got %0h want %0h", got_q[g0], d);
            end
        end
        checks++;
        if (vld_cyc - v0 !== 1) begin
            errors++;
            $display("FAIL single_vld: got %0d want 1", vld_cyc - v0);
        end
        checks++;
        if (fe_cnt - f0 + ov_cnt - o0 + pe_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL single_err: got %0d want 0",
                     fe_cnt - f0 + ov_cnt - o0 + pe_cnt - p0);
        end
    endtask

    task automatic test_glitch;
        int g0, f0;
        g0 = got_q.size(); f0 = fe_cnt + ov_cnt + pe_cnt;
        rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) period(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy1: got %b want 1", busy);
        end
        idle(8);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy0: got %b want 0", busy);
        end
        idle(OS * 12);
        checks++;
        if (got_q.size() !== g0 || fe_cnt + ov_cnt + pe_cnt !== f0) begin
            errors++;
            $display("FAIL glitch_none: got pushes %0d errs %0d want 0",
                     got_q.size() - g0, fe_cnt + ov_cnt + pe_cnt - f0);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_frame_err;
        int g0, f0;
        logic [DW-1:0] d;
        d = 8'h3C;
        g0 = got_q.size(); f0 = fe_cnt;
        rx_ready = 1'b1;
        send_frame(d, 1'b0, ^d, 1'b0);
        for (int i = 0; i < 12; i++) period(1'b0, 1'b0);
        checks++;
        if (fe_cnt - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_cnt: got %0d want 1", fe_cnt - f0);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL ferr_busy: got %b want 1", busy);
        end
        checks++;
        if (rx_valid !== 1'b0 || got_q.size() !== g0) begin
            errors++;
            $display("FAIL ferr_empty: got valid %b pushes %0d want 0 0",
                     rx_valid, got_q.size() - g0);
        end
        idle(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ferr_idle: got %b want 0", busy);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun;
        int g0, o0;
        logic [DW-1:0] d;
        g0 = got_q.size(); o0 = ov_cnt;
        rx_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            d = DW'(w);
            send_frame(d, 1'b1, ^d, 1'b0);
            if (w == 4) begin
                checks++;
                if (ov_cnt - o0 !== 0) begin
                    errors++;
                    $display("FAIL ovr_early: got %0d want 0", ov_cnt - o0);
                end
            end
        end
        idle(2);
        checks++;
        if (ov_cnt - o0 !== 1) begin
            errors++; $display("FAIL ovr_cnt: got %0d want 1", ov_cnt - o0);
        end
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
            errors++;
            $display("FAIL ovr_hold: got %b/%0h want 1/01", rx_valid, rx_data);
        end
        drain(8);
        checks++;
        if (got_q.size() - g0 !== 4) begin
            errors++;
            $display("FAIL ovr_pops: got %0d want 4", got_q.size() - g0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[g0+i] !== DW'(i + 1)) begin
                    errors++;
                    $display("FAIL ovr_word%0d: got %0h want %0h",
                             i, got_q[g0+i], i + 1);
                end
            end
        end
    endtask

    task automatic test_full_pop;
        int g0, o0;
        logic [DW-1:0] d;
        g0 = got_q.size(); o0 = ov_cnt;
        rx_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            d = DW'(w);
            send_frame(d, 1'b1, ^d, w == 5);
        end
        idle(2);
        checks++;
        if (ov_cnt - o0 !== 0) begin
            errors++; $display("FAIL fpop_ovr: got %0d want 0", ov_cnt - o0);
        end
        drain(8);
        checks++;
        if (got_q.size() - g0 !== 5) begin
            errors++;
            $display("FAIL fpop_pops: got %0d want 5", got_q.size() - g0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[g0+i] !== DW'(i + 1)) begin
                    errors++;
                    $display("FAIL fpop_word%0d: got %0h want %0h",
                             i, got_q[g0+i], i + 1);
                end
            end
        end
    endtask

    task automatic test_parity;
`ifdef SERIAL_RX_PARITY_EN
        int g0, p0;
        g0 = got_q.size(); p0 = pe_cnt;
        rx_ready = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(6);
        checks++;
        if (pe_cnt - p0 !== 1 || got_q.size() !== g0) begin
            errors++;
            $display("FAIL par_bad: got perr %0d pushes %0d want 1 0",
                     pe_cnt - p0, got_q.size() - g0);
        end
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(6);
        checks++;
        if (pe_cnt - p0 !== 1 || got_q.size() - g0 !== 1) begin
            errors++;
            $display("FAIL par_good: got perr %0d pushes %0d want 1 1",
                     pe_cnt - p0, got_q.size() - g0);
        end else begin
            checks++;
            if (got_q[g0] !== 8'h07) begin
                errors++;
                $display("FAIL par_data: got %0h want 07", got_q[g0]);
            end
        end
        rx_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_midframe;
        int g0, f0;
        g0 = got_q.size(); f0 = fe_cnt + ov_cnt + pe_cnt;
        rx_ready = 1'b1;
        for (int i = 0; i < OS * 3; i++) period(1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) period(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL mrst_busy: got %b want 0", busy);
        end
        idle(6);
        checks++;
        if (got_q.size() !== g0 || fe_cnt + ov_cnt + pe_cnt !== f0) begin
            errors++;
            $display("FAIL mrst_quiet: got pushes %0d errs %0d want 0",
                     got_q.size() - g0, fe_cnt + ov_cnt + pe_cnt - f0);
        end
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        idle(6);
        checks++;
        if (got_q.size() - g0 !== 1 || got_q[got_q.size()-1] !== 8'h5A) begin
            errors++;
            $display("FAIL mrst_next: got %0d words last %0h want 1 5a",
                     got_q.size() - g0, got_q[got_q.size()-1]);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_random;
        logic [DW-1:0] exp_q[$];
        int g0, f0, o0, p0, nbad;
        logic [DW-1:0] d;
        bit bad;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        nbad = 0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, !bad, ^d, 1'b0);
            if (bad) begin
                nbad++;
                for (int i = 0; i < 4; i++) period(1'b0, 1'b0);
                idle(4);
            end else begin
                exp_q.push_back(d);
                idle($urandom_range(0, 3));
            end
        end
        rand_rdy = 1'b0;
        drain(10);
        checks++;
        if (got_q.size() - g0 !== exp_q.size()) begin
            errors++;
            $display("FAIL rnd_cnt: got %0d want %0d",
                     got_q.size() - g0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[g0+i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_word%0d: got %0h want %0h",
                             i, got_q[g0+i], exp_q[i]);
                end
            end
        end
        checks++;
        if (fe_cnt - f0 !== nbad) begin
            errors++;
            $display("FAIL rnd_ferr: got %0d want %0d", fe_cnt - f0, nbad);
        end
        checks++;
        if (ov_cnt - o0 !== 0 || pe_cnt - p0 !== 0) begin
            errors++;
            $display("FAIL rnd_other: got ovr %0d perr %0d want 0 0",
                     ov_cnt - o0, pe_cnt - p0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_parity();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
